// File: rtl/vga_timing_pkg.sv
// Shared types, 640x480@60 default timings and the line/frame length helper
// for the VGA timing generator.
package vga_timing_pkg;

    typedef logic [9:0] pos_t;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int POS_LIMIT     = 1024;

    function automatic int total(input int display, input int front,
                                 input int sync, input int back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter with sync/active flags decoded from the
// value being loaded, so all three registers always describe the same position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   DISPLAY     = H_DISPLAY_DEF,
    parameter int   FRONT       = H_FRONT_DEF,
    parameter int   SYNC        = H_SYNC_DEF,
    parameter int   BACK        = H_BACK_DEF,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    output logic [9:0] o_pos,
    output logic       o_sync,
    output logic       o_active,
    output logic       o_wrap_next
);

    localparam pos_t LAST     = pos_t'(total(DISPLAY, FRONT, SYNC, BACK) - 1);
    localparam pos_t SYNC_LO  = pos_t'(DISPLAY + FRONT);
    localparam pos_t SYNC_HI  = pos_t'(DISPLAY + FRONT + SYNC - 1);
    localparam pos_t DISP_END = pos_t'(DISPLAY);

    logic [9:0] r_pos;
    logic       r_sync;
    logic       r_active;
    logic [9:0] w_pos_next;
    logic       w_wrap;

    assign w_wrap     = (r_pos == LAST);
    assign w_pos_next = w_wrap ? 10'd0 : r_pos + 10'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos    <= LAST;
            r_sync   <= ~SYNC_ACTIVE;
            r_active <= 1'b0;
        end else if (i_step) begin
            r_pos    <= w_pos_next;
            r_sync   <= (w_pos_next >= SYNC_LO && w_pos_next <= SYNC_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_active <= (w_pos_next < DISP_END);
        end
    end

    assign o_pos       = r_pos;
    assign o_sync      = r_sync;
    assign o_active    = r_active;
    assign o_wrap_next = w_wrap;

endmodule

// File: rtl/vga_timing_core.sv
// VGA pixel timing generator: horizontal/vertical scan counters, syncs,
// display window, line/frame strobes and a pausable frame counter.
module vga_timing_core
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = H_DISPLAY_DEF,
    parameter int   H_FRONT     = H_FRONT_DEF,
    parameter int   H_SYNC      = H_SYNC_DEF,
    parameter int   H_BACK      = H_BACK_DEF,
    parameter int   V_DISPLAY   = V_DISPLAY_DEF,
    parameter int   V_FRONT     = V_FRONT_DEF,
    parameter int   V_SYNC      = V_SYNC_DEF,
    parameter int   V_BACK      = V_BACK_DEF,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   FRAME_W     = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena_i,
    input  logic               freeze_i,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               display_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int   H_TOTAL = total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int   V_TOTAL = total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    // Last line before vsync; wrapping hpos out of it enters the vsync leading edge.
    localparam pos_t V_TICK  = pos_t'(V_DISPLAY + V_FRONT - 1);

    if (H_TOTAL > POS_LIMIT || V_TOTAL > POS_LIMIT) begin : g_bad_params
        $fatal(1, "vga_timing_core: H_TOTAL/V_TOTAL exceed 10-bit position range");
    end

    logic               w_h_wrap, w_v_wrap, w_v_step;
    logic               w_h_active, w_v_active;
    logic [9:0]         w_vpos;
    logic               r_line_start, r_frame_start;
    logic [FRAME_W-1:0] r_frame_count;

    assign w_v_step = ena_i & w_h_wrap;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .i_step(ena_i),
        .o_pos(hpos), .o_sync(hsync), .o_active(w_h_active), .o_wrap_next(w_h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .i_step(w_v_step),
        .o_pos(w_vpos), .o_sync(vsync), .o_active(w_v_active), .o_wrap_next(w_v_wrap)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= w_v_step;
            r_frame_start <= w_v_step & w_v_wrap;
            if (w_v_step && w_vpos == V_TICK && !freeze_i)
                r_frame_count <= r_frame_count + FRAME_W'(1);
        end
    end

    assign vpos        = w_vpos;
    assign display_on  = w_h_active & w_v_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_core.sv
// Scoreboard bench: a full-size 640x480 instance and a shrunken instance share
// one directed stimulus; expectations are queued per cycle and checked at negedge.
module tb_vga_timing_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena_i, freeze_i;
    logic [9:0] a_hpos, a_vpos, a_fc, b_hpos, b_vpos;
    logic [2:0] b_fc;
    logic       a_disp, a_hs, a_vs, a_ls, a_fs;
    logic       b_disp, b_hs, b_vs, b_ls, b_fs;

    vga_timing_core u_a (
        .clk(clk), .rst_n(rst_n), .ena_i(ena_i), .freeze_i(freeze_i),
        .hpos(a_hpos), .vpos(a_vpos), .display_on(a_disp), .hsync(a_hs), .vsync(a_vs),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_core #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b1), .FRAME_W(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .ena_i(ena_i), .freeze_i(freeze_i),
        .hpos(b_hpos), .vpos(b_vpos), .display_on(b_disp), .hsync(b_hs), .vsync(b_vs),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    localparam int HD[2] = '{640, 8};
    localparam int HF[2] = '{16, 2};
    localparam int HS[2] = '{96, 3};
    localparam int HB[2] = '{48, 3};
    localparam int VD[2] = '{480, 6};
    localparam int VF[2] = '{10, 2};
    localparam int VS[2] = '{2, 2};
    localparam int VB[2] = '{33, 2};
    localparam int SA[2] = '{0, 1};
    localparam int FW[2] = '{10, 3};

    localparam int S_HPOS = 0, S_VPOS = 1, S_DISP = 2, S_HS = 3, S_VS = 4,
                   S_LS = 5, S_FS = 6, S_FC = 7;

    typedef struct {
        int hp, vp, fc;
        bit disp, hs, vs, ls, fs;
    } obs_t;

    typedef struct {
        obs_t m0, m1;
        bit   hvalid;
        int   hinst, hsig, hval;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mh[2], mv[2], mfc[2];
    bit   mls[2], mfs[2];

    function automatic obs_t model_obs(int i);
        obs_t o;
        o.hp   = mh[i];
        o.vp   = mv[i];
        o.fc   = mfc[i];
        o.ls   = mls[i];
        o.fs   = mfs[i];
        o.disp = (mh[i] < HD[i]) && (mv[i] < VD[i]);
        o.hs   = (mh[i] >= HD[i] + HF[i] && mh[i] < HD[i] + HF[i] + HS[i]) ? (SA[i] != 0) : (SA[i] == 0);
        o.vs   = (mv[i] >= VD[i] + VF[i] && mv[i] < VD[i] + VF[i] + VS[i]) ? (SA[i] != 0) : (SA[i] == 0);
        return o;
    endfunction

    task automatic model_step(bit r, bit e, bit f);
        for (int i = 0; i < 2; i++) begin
            int ht = HD[i] + HF[i] + HS[i] + HB[i];
            int vt = VD[i] + VF[i] + VS[i] + VB[i];
            if (!r) begin
                mh[i] = ht - 1; mv[i] = vt - 1; mfc[i] = 0; mls[i] = 0; mfs[i] = 0;
            end else if (e) begin
                if (mh[i] == ht - 1) begin
                    mh[i] = 0;
                    mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
                end else begin
                    mh[i] = mh[i] + 1;
                end
                mls[i] = (mh[i] == 0);
                mfs[i] = mls[i] && (mv[i] == 0);
                if (mh[i] == 0 && mv[i] == VD[i] + VF[i] && !f)
                    mfc[i] = (mfc[i] + 1) % (1 << FW[i]);
            end else begin
                mls[i] = 0; mfs[i] = 0;
            end
        end
    endtask

    task automatic step(bit r, bit e, bit f, int hinst = -1, int hsig = 0, int hval = 0);
        exp_t x;
        rst_n = r; ena_i = e; freeze_i = f;
        model_step(r, e, f);
        x.m0 = model_obs(0);
        x.m1 = model_obs(1);
        x.hvalid = (hinst >= 0);
        x.hinst = hinst; x.hsig = hsig; x.hval = hval;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t dut_obs(int i);
        obs_t o;
        if (i == 0) begin
            o.hp = int'(a_hpos); o.vp = int'(a_vpos); o.fc = int'(a_fc);
            o.disp = a_disp; o.hs = a_hs; o.vs = a_vs; o.ls = a_ls; o.fs = a_fs;
        end else begin
            o.hp = int'(b_hpos); o.vp = int'(b_vpos); o.fc = int'(b_fc);
            o.disp = b_disp; o.hs = b_hs; o.vs = b_vs; o.ls = b_ls; o.fs = b_fs;
        end
        return o;
    endfunction

    function automatic int sig_of(obs_t o, int s);
        case (s)
            S_HPOS:  return o.hp;
            S_VPOS:  return o.vp;
            S_DISP:  return int'(o.disp);
            S_HS:    return int'(o.hs);
            S_VS:    return int'(o.vs);
            S_LS:    return int'(o.ls);
            S_FS:    return int'(o.fs);
            default: return o.fc;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_HPOS:  return "hpos";
            S_VPOS:  return "vpos";
            S_DISP:  return "display_on";
            S_HS:    return "hsync";
            S_VS:    return "vsync";
            S_LS:    return "line_start";
            S_FS:    return "frame_start";
            default: return "frame_count";
        endcase
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(string p, obs_t a, obs_t e);
        for (int s = 0; s <= S_FC; s++)
            chk({p, "_", sig_name(s)}, sig_of(a, s), sig_of(e, s));
    endtask

    // Monitor: one queued expectation per clock, compared away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        if (q.size() != 0) begin
            x = q.pop_front();
            cmp_obs("full", dut_obs(0), x.m0);
            cmp_obs("small", dut_obs(1), x.m1);
            if (x.hvalid)
                chk($sformatf("dir%0d_%s", x.hinst, sig_name(x.hsig)),
                    sig_of(dut_obs(x.hinst), x.hsig), x.hval);
        end
    end

    task automatic seek_small(int h, int v, string nm);
        int n = 0;
        while (!(mh[1] == h && mv[1] == v) && n < 400) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL seek_%s actual=timeout expected=(%0d,%0d)", nm, h, v);
        end
    endtask

    initial begin
        int hi, hs, hv, hp;
        // Reset dominates ena_i/freeze_i.
        step(1'b0, 1'b1, 1'b1, 0, S_HPOS, 799);
        step(1'b0, 1'b1, 1'b1, 1, S_HPOS, 15);
        step(1'b0, 1'b0, 1'b0, 0, S_VPOS, 524);

        // Line 0 of the full-size raster, then the wrap into line 1.
        for (int k = 1; k <= 801; k++) begin
            hp = (k - 1) % 800;
            hi = -1; hs = 0; hv = 0;
            if (k == 1)         begin hi = 0; hs = S_FS;   hv = 1; end
            else if (k == 801)  begin hi = 0; hs = S_VPOS; hv = 1; end
            else if (hp == 639) begin hi = 0; hs = S_DISP; hv = 1; end
            else if (hp == 640) begin hi = 0; hs = S_DISP; hv = 0; end
            else if (hp == 655) begin hi = 0; hs = S_HS;   hv = 1; end
            else if (hp == 656) begin hi = 0; hs = S_HS;   hv = 0; end
            else if (hp == 751) begin hi = 0; hs = S_HS;   hv = 0; end
            else if (hp == 752) begin hi = 0; hs = S_HS;   hv = 1; end
            step(1'b1, 1'b1, 1'b0, hi, hs, hv);
        end

        // Hold for 7 cycles at hpos 100.
        repeat (100) step(1'b1, 1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0, 0, S_HPOS, 100);
        step(1'b1, 1'b1, 1'b0, 0, S_HPOS, 101);

        // Paused animation across one full small frame, then run past the counter wrap.
        hv = mfc[1];
        repeat (192) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1, S_FC, hv);
        repeat (192 * 8) step(1'b1, 1'b1, 1'b0);

        // Disable right on a frame start: strobes drop, position holds.
        seek_small(0, 0, "frame0");
        step(1'b1, 1'b0, 1'b0, 1, S_FS, 0);
        step(1'b1, 1'b1, 1'b0);

        // Reset mid-frame, then resume at (0,0).
        seek_small(5, 4, "midframe");
        step(1'b0, 1'b1, 1'b1, 1, S_HPOS, 15);
        step(1'b1, 1'b1, 1'b0, 1, S_FS, 1);
        repeat (20) step(1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
